// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use and
// MDU-occupancy stalls, EX branch flushes, and a saturating stall-cycle counter.
//
// state       | meaning
// ST_RUN      | MDU idle; a mult/div in ID may be accepted
// ST_MDU_BUSY | MDU occupied; mdu_cnt_q counts remaining cycles down to 0
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic [4:0]  in_id_rs,
    input  logic [4:0]  in_id_rt,
    input  logic        in_id_uses_rs,
    input  logic        in_id_uses_rt,
    input  logic        in_id_mdu_start,
    input  logic        in_id_reads_hilo,
    input  logic        in_ex_memread,
    input  logic [4:0]  in_ex_wreg,
    input  logic        in_ex_branch_taken,
    output logic        out_pc_we,
    output logic        out_if_id_stall,
    output logic        out_if_id_flush,
    output logic        out_id_ex_flush,
    output logic        out_mdu_busy,
    output logic [15:0] out_stall_cycles
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 1);
    localparam logic [15:0]      STALL_MAX = 16'hFFFF;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic lu;
    logic mh;
    logic stall;
    logic mdu_accept;

    always_comb begin
        lu = in_ex_memread && (in_ex_wreg != 5'd0) &&
             ((in_id_uses_rs && (in_id_rs == in_ex_wreg)) ||
              (in_id_uses_rt && (in_id_rt == in_ex_wreg)));
        mh = (state_q == ST_MDU_BUSY) && (in_id_mdu_start || in_id_reads_hilo);
        // A taken branch discards the ID instruction, so it never needs to stall.
        stall = (lu || mh) && !in_ex_branch_taken;
        mdu_accept = (state_q == ST_RUN) && in_id_mdu_start &&
                     !in_ex_branch_taken && !lu;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= ST_RUN;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mdu_accept) begin
                    state_d   = ST_MDU_BUSY;
                    mdu_cnt_d = CNT_INIT;
                end
            end
            ST_MDU_BUSY: begin
                if (mdu_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    mdu_cnt_d = mdu_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = ST_RUN;
                mdu_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        out_if_id_stall  = stall;
        out_pc_we        = !stall;
        out_if_id_flush  = in_ex_branch_taken;
        out_id_ex_flush  = stall || in_ex_branch_taken;
        out_mdu_busy     = (state_q == ST_MDU_BUSY);
        out_stall_cycles = stall_cnt_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random stimulus against
// a cycle-level model tracking remaining MDU cycles and total stall cycles.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 8;

    logic        in_clk;
    logic        in_rst;
    logic [4:0]  in_id_rs;
    logic [4:0]  in_id_rt;
    logic        in_id_uses_rs;
    logic        in_id_uses_rt;
    logic        in_id_mdu_start;
    logic        in_id_reads_hilo;
    logic        in_ex_memread;
    logic [4:0]  in_ex_wreg;
    logic        in_ex_branch_taken;
    logic        out_pc_we;
    logic        out_if_id_stall;
    logic        out_if_id_flush;
    logic        out_id_ex_flush;
    logic        out_mdu_busy;
    logic [15:0] out_stall_cycles;

    int checks = 0;
    int failures = 0;

    int m_busy_left = 0;
    int m_stall = 0;

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(6)) dut (
        .in_clk             (in_clk),
        .in_rst             (in_rst),
        .in_id_rs           (in_id_rs),
        .in_id_rt           (in_id_rt),
        .in_id_uses_rs      (in_id_uses_rs),
        .in_id_uses_rt      (in_id_uses_rt),
        .in_id_mdu_start    (in_id_mdu_start),
        .in_id_reads_hilo   (in_id_reads_hilo),
        .in_ex_memread      (in_ex_memread),
        .in_ex_wreg         (in_ex_wreg),
        .in_ex_branch_taken (in_ex_branch_taken),
        .out_pc_we          (out_pc_we),
        .out_if_id_stall    (out_if_id_stall),
        .out_if_id_flush    (out_if_id_flush),
        .out_id_ex_flush    (out_id_ex_flush),
        .out_mdu_busy       (out_mdu_busy),
        .out_stall_cycles   (out_stall_cycles)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    function automatic logic m_lu();
        return in_ex_memread && (in_ex_wreg != 0) &&
               ((in_id_uses_rs && in_id_rs == in_ex_wreg) ||
                (in_id_uses_rt && in_id_rt == in_ex_wreg));
    endfunction

    function automatic logic m_s();
        return (m_lu() || (m_busy_left > 0 && (in_id_mdu_start || in_id_reads_hilo)))
               && !in_ex_branch_taken;
    endfunction

    task automatic model_adv();
        logic s;
        s = m_s();
        if (m_busy_left > 0) m_busy_left--;
        else if (in_id_mdu_start && !in_ex_branch_taken && !m_lu()) m_busy_left = LAT;
        if (s && m_stall < 65535) m_stall++;
    endtask

    task automatic clear_inputs();
        in_id_rs = 0; in_id_rt = 0; in_id_uses_rs = 0; in_id_uses_rt = 0;
        in_id_mdu_start = 0; in_id_reads_hilo = 0; in_ex_memread = 0;
        in_ex_wreg = 0; in_ex_branch_taken = 0;
    endtask

    // Advance one clock; model sees the inputs that the DUT sampled.
    task automatic tick();
        @(posedge in_clk);
        model_adv();
        #1;
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        clear_inputs();
        m_busy_left = 0;
        m_stall = 0;
        @(posedge in_clk);
        #3;
        in_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_pc_we !== 1'b1) begin failures++; $display("FAIL reset_pc_we got=%b exp=1", out_pc_we); end
        checks++; if (out_if_id_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", out_if_id_stall); end
        checks++; if (out_if_id_flush !== 1'b0) begin failures++; $display("FAIL reset_if_id_flush got=%b exp=0", out_if_id_flush); end
        checks++; if (out_id_ex_flush !== 1'b0) begin failures++; $display("FAIL reset_id_ex_flush got=%b exp=0", out_id_ex_flush); end
        checks++; if (out_mdu_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", out_mdu_busy); end
        checks++; if (out_stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_stall_cycles got=%0d exp=0", out_stall_cycles); end
    endtask

    task automatic test_load_use();
        do_reset();
        tick();
        in_ex_memread = 1; in_ex_wreg = 8; in_id_rs = 8; in_id_uses_rs = 1;
        in_id_mdu_start = 1;
        #1;
        checks++; if (out_if_id_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", out_if_id_stall); end
        checks++; if (out_pc_we !== 1'b0) begin failures++; $display("FAIL lu_pc_we got=%b exp=0", out_pc_we); end
        checks++; if (out_id_ex_flush !== 1'b1) begin failures++; $display("FAIL lu_id_ex_flush got=%b exp=1", out_id_ex_flush); end
        checks++; if (out_if_id_flush !== 1'b0) begin failures++; $display("FAIL lu_if_id_flush got=%b exp=0", out_if_id_flush); end
        tick();
        clear_inputs();
        #1;
        checks++; if (out_if_id_stall !== 1'b0) begin failures++; $display("FAIL lu_one_cycle got=%b exp=0", out_if_id_stall); end
        checks++; if (out_mdu_busy !== 1'b0) begin failures++; $display("FAIL lu_blocks_start got=%b exp=0", out_mdu_busy); end
        checks++; if (out_stall_cycles !== 16'd1) begin failures++; $display("FAIL lu_stall_cycles got=%0d exp=1", out_stall_cycles); end
        in_ex_memread = 1; in_ex_wreg = 0; in_id_rs = 0; in_id_uses_rs = 1;
        #1;
        checks++; if (out_if_id_stall !== 1'b0) begin failures++; $display("FAIL lu_r0 got=%b exp=0", out_if_id_stall); end
        in_ex_wreg = 13; in_id_rt = 13; in_id_uses_rt = 1; in_id_rs = 2;
        #1;
        checks++; if (out_if_id_stall !== 1'b1) begin failures++; $display("FAIL lu_rt got=%b exp=1", out_if_id_stall); end
        in_id_uses_rt = 0;
        #1;
        checks++; if (out_if_id_stall !== 1'b0) begin failures++; $display("FAIL lu_rt_unused got=%b exp=0", out_if_id_stall); end
        tick();
        clear_inputs();
    endtask

    task automatic test_mdu();
        do_reset();
        tick();
        in_id_mdu_start = 1;
        #1;
        checks++; if (out_if_id_stall !== 1'b0) begin failures++; $display("FAIL mdu_accept_stall got=%b exp=0", out_if_id_stall); end
        checks++; if (out_mdu_busy !== 1'b0) begin failures++; $display("FAIL mdu_accept_busy got=%b exp=0", out_mdu_busy); end
        tick();
        in_id_mdu_start = 0; in_id_reads_hilo = 1;
        for (int i = 1; i <= LAT; i++) begin
            #1;
            checks++; if (out_mdu_busy !== 1'b1) begin failures++; $display("FAIL mdu_busy_t+%0d got=%b exp=1", i, out_mdu_busy); end
            checks++; if (out_if_id_stall !== 1'b1 || out_pc_we !== 1'b0) begin failures++; $display("FAIL mdu_stall_t+%0d got=%b/%b exp=1/0", i, out_if_id_stall, out_pc_we); end
            tick();
        end
        #1;
        checks++; if (out_mdu_busy !== 1'b0) begin failures++; $display("FAIL mdu_busy_end got=%b exp=0", out_mdu_busy); end
        checks++; if (out_if_id_stall !== 1'b0) begin failures++; $display("FAIL mdu_mflo_proceeds got=%b exp=0", out_if_id_stall); end
        checks++; if (out_stall_cycles !== 16'(LAT)) begin failures++; $display("FAIL mdu_stall_cycles got=%0d exp=%0d", out_stall_cycles, LAT); end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        tick();
        in_ex_memread = 1; in_ex_wreg = 5; in_id_rs = 5; in_id_uses_rs = 1;
        in_ex_branch_taken = 1;
        #1;
        checks++; if (out_if_id_stall !== 1'b0) begin failures++; $display("FAIL br_lu_stall got=%b exp=0", out_if_id_stall); end
        checks++; if (out_if_id_flush !== 1'b1) begin failures++; $display("FAIL br_lu_if_id_flush got=%b exp=1", out_if_id_flush); end
        checks++; if (out_id_ex_flush !== 1'b1) begin failures++; $display("FAIL br_lu_id_ex_flush got=%b exp=1", out_id_ex_flush); end
        checks++; if (out_pc_we !== 1'b1) begin failures++; $display("FAIL br_lu_pc_we got=%b exp=1", out_pc_we); end
        clear_inputs();
        in_ex_branch_taken = 1; in_id_mdu_start = 1;
        tick();
        clear_inputs();
        #1;
        checks++; if (out_mdu_busy !== 1'b0) begin failures++; $display("FAIL br_blocks_start got=%b exp=0", out_mdu_busy); end
        checks++; if (out_if_id_flush !== 1'b0) begin failures++; $display("FAIL br_flush_one_cycle got=%b exp=0", out_if_id_flush); end
        in_id_mdu_start = 1;
        tick();
        in_id_mdu_start = 0; in_id_reads_hilo = 1; in_ex_branch_taken = 1;
        #1;
        checks++; if (out_if_id_stall !== 1'b0 || out_mdu_busy !== 1'b1) begin failures++; $display("FAIL br_over_mh got=%b/%b exp=0/1", out_if_id_stall, out_mdu_busy); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_mdu();
        do_reset();
        tick();
        in_id_mdu_start = 1;
        tick();
        in_id_mdu_start = 0; in_id_reads_hilo = 1;
        tick();
        tick();
        #2;
        in_rst = 1'b1;
        #1;
        checks++; if (out_mdu_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", out_mdu_busy); end
        checks++; if (out_if_id_stall !== 1'b0) begin failures++; $display("FAIL rst_mid_state_run got=%b exp=0", out_if_id_stall); end
        checks++; if (out_stall_cycles !== 16'd0) begin failures++; $display("FAIL rst_mid_stall_cycles got=%0d exp=0", out_stall_cycles); end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        tick();
        for (int c = 0; c < 2000; c++) begin
            in_id_rs = 5'($urandom_range(0, 3));
            in_id_rt = 5'($urandom_range(0, 3));
            in_ex_wreg = 5'($urandom_range(0, 3));
            in_id_uses_rs = 1'($urandom_range(0, 1));
            in_id_uses_rt = 1'($urandom_range(0, 1));
            in_ex_memread = ($urandom_range(0, 3) == 0);
            in_id_mdu_start = ($urandom_range(0, 5) == 0);
            in_id_reads_hilo = ($urandom_range(0, 3) == 0);
            in_ex_branch_taken = ($urandom_range(0, 7) == 0);
            #1;
            checks++; if (out_if_id_stall !== m_s() || out_pc_we !== !m_s()) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b/%b exp=%b", c, out_if_id_stall, out_pc_we, m_s()); end
            checks++; if (out_if_id_flush !== in_ex_branch_taken || out_id_ex_flush !== (m_s() || in_ex_branch_taken)) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%b/%b", c, out_if_id_flush, out_id_ex_flush); end
            checks++; if (out_mdu_busy !== (m_busy_left > 0)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, out_mdu_busy, m_busy_left > 0); end
            checks++; if (out_stall_cycles !== 16'(m_stall)) begin failures++; $display("FAIL rnd_stall_cycles cyc=%0d got=%0d exp=%0d", c, out_stall_cycles, m_stall); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        int guard;
        int extra;
        do_reset();
        tick();
        in_id_mdu_start = 1; in_id_reads_hilo = 1;
        guard = 0;
        extra = 0;
        while (extra < 40 && guard < 80000) begin
            tick();
            guard++;
            if (m_stall == 65535) extra++;
            checks++;
            if (out_stall_cycles !== 16'(m_stall)) begin
                failures++;
                if (failures < 10) $display("FAIL sat_track cyc=%0d got=%0d exp=%0d", guard, out_stall_cycles, m_stall);
            end
        end
        checks++; if (extra < 40) begin failures++; $display("FAIL sat_timeout got=%0d exp=65535", m_stall); end
        checks++; if (out_stall_cycles !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", out_stall_cycles); end
        clear_inputs();
    endtask

    initial begin
        in_rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_mdu();
        test_branch();
        test_reset_mid_mdu();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
